// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch block.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INCR   = 4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load takes priority over increment.
// align_i selects a word-aligned target; when clear the raw target is loaded.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned            REG_SIZE = 32,
    parameter logic [REG_SIZE-1:0]    RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                incr_i,
    input  logic                align_i,
    input  logic [REG_SIZE-1:0] target_i,
    output logic [REG_SIZE-1:0] pc_o
);

    logic [REG_SIZE-1:0] pc_q, pc_d, target_sel;

    // Choose aligned or raw redirect target
    always_comb begin
        target_sel = align_i ? {target_i[REG_SIZE-1:2], 2'b00} : target_i;
    end

    // Next PC: redirect beats sequential increment; increment wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = target_sel;
        else if (incr_i)
            pc_d = pc_q + REG_SIZE'(PC_INCR);
    end

    // PC state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator with IF/ID output register and valid/ready.
// Optional feature: FETCH_MISALIGN_TRAP_EN adds misalign_o and halts on a
// misaligned redirect instead of force-aligning the target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            REG_SIZE = 32,
    parameter logic [REG_SIZE-1:0]    RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [REG_SIZE-1:0] imem_addr_o,
    input  logic [REG_SIZE-1:0] imem_inst_i,
    input  logic                redirect_i,
    input  logic [REG_SIZE-1:0] redirect_pc_i,
    input  logic                halt_i,
    output logic [REG_SIZE-1:0] instr_o,
    output logic [REG_SIZE-1:0] pc_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                halted_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                misalign_o
`endif
);

    fetch_state_e        state_q, state_d;
    logic [REG_SIZE-1:0] pc_q;
    logic [REG_SIZE-1:0] instr_q, instr_d;
    logic [REG_SIZE-1:0] pco_q, pco_d;
    logic                valid_q, valid_d;
    logic                capture;
    logic                redir_raw;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign redir_raw  = (redirect_pc_i[1:0] != 2'b00);
    assign misalign_o = misalign_q;
`else
    assign redir_raw  = 1'b0;
`endif

    pc_reg #(
        .REG_SIZE (REG_SIZE),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (redirect_i),
        .incr_i   (capture),
        .align_i  (!redir_raw),
        .target_i (redirect_pc_i),
        .pc_o     (pc_q)
    );

    // Next state and output-stage update; redirect > halt > fetch
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        valid_d = valid_q;
        capture = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (redirect_i) begin
            // Flush regardless of ready_i; a raw (trapping) target parks in HALTED
            valid_d = 1'b0;
            state_d = redir_raw ? HALTED : FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d = redir_raw;
`endif
        end else begin
            unique case (state_q)
                BOOT:   state_d = halt_i ? HALTED : FETCH;
                FETCH: begin
                    capture = !valid_q || ready_i;
                    if (halt_i) state_d = HALTED;
                end
                HALTED: if (ready_i) valid_d = 1'b0;
                default: state_d = BOOT;
            endcase
        end
        if (capture) begin
            instr_d = imem_inst_i;
            pco_d   = pc_q;
            valid_d = 1'b1;
        end
    end

    // FSM and IF/ID output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            instr_q <= REG_SIZE'(NOP_INSTR);
            pco_q   <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = pco_q;
    assign valid_o     = valid_q;
    assign halted_o    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] imem_addr_o, imem_inst_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic [31:0] instr_o, pc_o;
    logic        valid_o, halted_o;
    logic        ready_i = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_chk = 0;
    int n_fail = 0;

    fetch_unit #(.REG_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_addr_o   (imem_addr_o),
        .imem_inst_i   (imem_inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .halted_o      (halted_o)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory contents
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h11;
            32'h4:   mem = 32'h22;
            32'h8:   mem = 32'h33;
            default: mem = {a[31:2], 2'b11} ^ 32'hA500_0000;
        endcase
    endfunction

    always_comb imem_inst_i = mem(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage must hold after each edge
    logic [31:0] m_pc = 32'h0, m_instr = NOP_INSTR, m_pco = 32'h0;
    logic        m_valid = 1'b0, m_boot = 1'b1, m_halt = 1'b0, m_mis = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pc <= 32'h0; m_instr <= NOP_INSTR; m_pco <= 32'h0;
            m_valid <= 1'b0; m_boot <= 1'b1; m_halt <= 1'b0; m_mis <= 1'b0;
        end else if (redirect_i) begin
            if (TRAP && redirect_pc_i[1:0] != 2'b00) begin
                m_pc <= redirect_pc_i; m_halt <= 1'b1; m_mis <= 1'b1;
            end else begin
                m_pc <= redirect_pc_i & 32'hFFFF_FFFC; m_halt <= 1'b0; m_mis <= 1'b0;
            end
            m_valid <= 1'b0;
            m_boot  <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_halt <= halt_i;
        end else if (m_halt) begin
            if (ready_i) m_valid <= 1'b0;
        end else begin
            if (!m_valid || ready_i) begin
                m_instr <= mem(m_pc);
                m_pco   <= m_pc;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end
            if (halt_i) m_halt <= 1'b1;
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk_i) begin
        chk("m_valid",  {31'b0, valid_o},  {31'b0, m_valid});
        chk("m_instr",  instr_o,           m_instr);
        chk("m_pc_o",   pc_o,              m_pco);
        chk("m_addr",   imem_addr_o,       m_pc);
        chk("m_halted", {31'b0, halted_o}, {31'b0, m_halt});
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("m_misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
    end

    initial begin
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_halted", {31'b0, halted_o}, 32'd0);
        rst_ni = 1'b1;

        @(negedge clk_i);
        chk("boot_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        chk("i0_instr", instr_o, 32'h11); chk("i0_pc", pc_o, 32'h0);
        @(negedge clk_i);
        chk("i1_instr", instr_o, 32'h22); chk("i1_pc", pc_o, 32'h4);
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_instr", instr_o, 32'h22);
            chk("stall_pc", pc_o, 32'h4);
            chk("stall_valid", {31'b0, valid_o}, 32'd1);
            chk("stall_addr", imem_addr_o, 32'h8);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("i2_instr", instr_o, 32'h33); chk("i2_pc", pc_o, 32'h8);

        // Redirect while stalled flushes the held instruction
        ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        @(negedge clk_i);
        chk("redir_valid", {31'b0, valid_o}, 32'd0);
        chk("redir_addr", imem_addr_o, 32'h100);
        redirect_i = 1'b0; ready_i = 1'b1;
        @(negedge clk_i);
        chk("redir_instr", instr_o, 32'hA500_0103);
        chk("redir_pc", pc_o, 32'h100);

        // Halt: last capture still happens, then fetch freezes
        halt_i = 1'b1;
        @(negedge clk_i);
        chk("halt_flag", {31'b0, halted_o}, 32'd1);
        chk("halt_pc", pc_o, 32'h104);
        chk("halt_addr", imem_addr_o, 32'h108);
        halt_i = 1'b0;
        @(negedge clk_i);
        chk("halt_drain", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        chk("halt_frozen", imem_addr_o, 32'h108);
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        @(negedge clk_i);
        chk("resume_halted", {31'b0, halted_o}, 32'd0);
        chk("resume_addr", imem_addr_o, 32'h40);
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("resume_instr", instr_o, 32'hA500_0043);
        chk("resume_pc", pc_o, 32'h40);

        // PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("wrap_pc0", pc_o, 32'hFFFF_FFFC);
        chk("wrap_instr0", instr_o, 32'h5AFF_FFFF);
        @(negedge clk_i);
        chk("wrap_pc1", pc_o, 32'h0);
        chk("wrap_instr1", instr_o, 32'h11);

        // Misaligned redirect target
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        @(negedge clk_i);
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", {31'b0, misalign_o}, 32'd1);
        chk("mis_halted", {31'b0, halted_o}, 32'd1);
        chk("mis_valid", {31'b0, valid_o}, 32'd0);
        chk("mis_addr", imem_addr_o, 32'h102);
        @(negedge clk_i);
        chk("mis_hold", {31'b0, valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk("mis_clear", {31'b0, misalign_o}, 32'd0);
        chk("mis_resume", imem_addr_o, 32'h200);
        @(negedge clk_i);
        chk("mis_resume_pc", pc_o, 32'h200);
`else
        chk("align_addr", imem_addr_o, 32'h100);
        chk("align_halted", {31'b0, halted_o}, 32'd0);
        @(negedge clk_i);
        chk("align_pc", pc_o, 32'h100);
`endif

        // Asynchronous reset with a live instruction pending
        @(negedge clk_i);
        chk("pre_rst_valid", {31'b0, valid_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_valid", {31'b0, valid_o}, 32'd0);
        chk("async_instr", instr_o, 32'h0000_0013);
        chk("async_pc_o", pc_o, 32'h0);
        chk("async_addr", imem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reboot_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        chk("reboot_instr", instr_o, 32'h11);
        chk("reboot_pc", pc_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the instruction memory.
- Owns the program counter and drives the byte address to the memory. Receives the combinational instruction word back.
- Registers the instruction and its PC into an IF/ID output stage with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute and a halt request.

Parameters:
- REG_SIZE, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- imem_addr_o  output  REG_SIZE  byte address to instruction memory; equals current PC.
- imem_inst_i  input  REG_SIZE  instruction word from memory, combinational from imem_addr_o.
- redirect_i  input  1  load new PC this cycle (branch/jump taken).
- redirect_pc_i  input  REG_SIZE  redirect target byte address.
- halt_i  input  1  stop fetching after the current cycle.
- instr_o  output  REG_SIZE  registered instruction to decode.
- pc_o  output  REG_SIZE  PC of instr_o.
- valid_o  output  1  instr_o/pc_o hold a live instruction.
- ready_i  input  1  decode accepts instr_o this cycle.
- halted_o  output  1  FSM in HALTED.

Behaviour:
- Reset (async assert, sync-safe deassert is the system's job):
  - pc_q=RESET_PC, state=BOOT, valid_o=0.
  - instr_o=32'h0000_0013 (NOP), pc_o=0, halted_o=0.
- imem_addr_o = pc_q, purely combinational, in all states.
- FSM states BOOT, FETCH, HALTED.
  - BOOT: lasts exactly one cycle after reset release, no capture. Next state is FETCH, or FETCH with the redirect target if redirect_i=1.
  - FETCH:
    - Output slot free = (!valid_o) || ready_i.
    - If free and no redirect: instr_o<=imem_inst_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4.
    - If not free: pc_q, instr_o, pc_o, valid_o all hold. Output must be stable while valid_o=1 and ready_i=0.
  - HALTED: no captures, pc_q holds. valid_o clears when the held instruction is consumed (ready_i=1). halted_o=1.
- Transitions:
  - FETCH -> HALTED on halt_i=1 with no redirect. The capture in that same cycle still happens if the slot is free.
  - HALTED exits only on redirect_i.
- Redirect priority: redirect_i > halt_i > normal fetch, in every state.
  - On redirect: pc_q <= {redirect_pc_i[31:2],2'b00}, valid_o <= 0 (flush, even if ready_i=0), state <= FETCH.
  - No capture occurs in the redirect cycle.
- Latency: the instruction at address A appears on instr_o the cycle after pc_q=A, if the slot is free. After a redirect, the first valid target instruction appears 2 cycles after redirect_i.
- Arithmetic: PC increment is modulo 2^REG_SIZE; 32'hFFFF_FFFC+4 = 32'h0000_0000. No carry out.
- Handshake: a transfer occurs iff valid_o && ready_i at the clock edge. Each fetched instruction is transferred exactly once, in order, unless flushed by a redirect.
- Reset mid-operation clears everything immediately, including a pending valid_o. The first fetch after reset is again at RESET_PC.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- With the macro defined:
  - Extra output port misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 does not align. It loads pc_q with the raw target, flushes, enters HALTED, and sets misalign_o=1 (sticky).
  - A later aligned redirect clears misalign_o and resumes FETCH.
- Without the macro: no misalign_o port. Targets are always force-aligned as above.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant (32'h0000_0013);
  - the fetch_state_e enum {BOOT, FETCH, HALTED};
  - PC_INCR constant (4).
- One natural sub-module, pc_reg: PC register with async active-low reset, load (redirect) and increment enables. It makes the aligned/raw target selection explicit.
- The FSM and the output register stay in fetch_unit.

Test Plan:
- Reset release, memory holds 0x11,0x22,0x33 at bytes 0,4,8, ready_i=1 -> cycle 1 BOOT valid_o=0. Then instr_o=0x11/pc_o=0, 0x22/4, 0x33/8 on consecutive cycles.
- ready_i=0 for 3 cycles while instr_o=0x22 -> instr_o, pc_o, valid_o and imem_addr_o=8 stable. Resume delivers 0x33/8 with no loss or duplicate.
- redirect_i with redirect_pc_i=0x100 while valid_o=1, ready_i=0 -> valid_o=0 next cycle. imem_addr_o=0x100, then instr at 0x100 with pc_o=0x100.
- halt_i=1 in FETCH -> halted_o=1 next cycle, fetches stop, pc frozen. Redirect to 0x40 -> halted_o=0, fetch resumes at 0x40.
- Redirect to 0xFFFF_FFFC -> pc_o sequence 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Redirect to 0x102:
  - with FETCH_MISALIGN_TRAP_EN -> misalign_o=1, halted_o=1, valid_o=0;
  - without the macro -> fetch resumes at 0x100.
- Async: rst_ni low mid-stream with valid_o=1 -> valid_o=0 and instr_o=NOP immediately, without a clock edge.
